j68_decode_arb: RTL and testbench
=================================

# j68_decode_arb

Two-port arbiter that shares the single synchronous-read j68 decode ROM (256 x 36-bit, one-cycle read latency) between the instruction decoder and the exception/trace sequencer. It grants at most one lookup per cycle, drives the ROM address and tags each read. One cycle after the ROM returns the data, it delivers the registered 36-bit entry to the requester that issued the lookup. It sits between the two requesters and the decode ROM instance inside the j68 core.

## Interface
Parameters:
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 36: ROM word width.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  core clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`  in  1  lookup request from the instruction decoder.
- `addr0`  in  8  ROM address for requester 0.
- `ack0`  out  1  combinational grant to requester 0 in the current cycle.
- `rvalid0`  out  1  one-cycle pulse: `rdata0` is new.
- `rdata0`  out  36  registered ROM word for requester 0.
- `req1`, `addr1`, `ack1`, `rvalid1`, `rdata1`: the same signals for requester 1 (exception/trace sequencer).
- `rom_address`  out  8  address to the decode ROM.
- `rom_q`  in  36  ROM output, valid one cycle after the address was presented.
- `busy`  out  1  high while a granted read has not yet been delivered.

## Operation
- Request rule: a requester holds `reqX` and `addrX` stable until it sees `ackX` high in a cycle. `reqX` may drop the cycle after that.
- Grant rule:
  - At most one of `ack0`/`ack1` is high per cycle.
  - When only one requester is asserting its request, that requester is granted in the same cycle (zero wait).
- Round-robin arbitration:
  - A 1-bit pointer `last` records which requester was granted most recently.
  - When both requests are high, the requester not equal to `last` wins, and `last` updates on the grant edge.
  - Reset value of `last` is 1, so requester 0 wins the first contention.
- ROM address:
  - `rom_address` is a combinational mux: `addrX` of the granted requester.
  - With no grant, it equals a register `hold_addr`, which captures each granted address (reset value 0x00). This avoids needless ROM address toggling.
- Pipeline (grant in cycle N):
  - Stage 1, edge ending cycle N: register `s1_vld`=1 and `s1_tag`=granted index.
  - Stage 2, cycle N+1: `rom_q` is valid. On the edge ending N+1, `rdataT` <= `rom_q`, and `rvalidT` is set for cycle N+2 only.
  - A new grant may be issued every cycle (full throughput). Back-to-back grants to alternating requesters produce alternating `rvalid` pulses in order.
- `rdataX` holds its value until the next delivery to the same requester. Delivery to the other requester does not disturb it.
- `busy` = `s1_vld` OR (grant this cycle).
- Reset:
  - Clears `s1_vld`, `rvalid0`, `rvalid1`, `rdata0`, `rdata1` (all 0), `hold_addr` (0x00) and `last` (1).
  - A read in flight when reset is asserted is discarded: no `rvalid` is produced for it after reset deasserts.
  - `ack0`/`ack1` are forced to 0 while `reset` is high.

## Timing
- Lookup latency: grant cycle N -> `rvalidX` high in cycle N+2, with `rdataX` valid from N+2 onward.
- Throughput: one lookup per cycle across both requesters. Under continuous contention each requester gets one grant every 2 cycles.
- Combinational paths:
  - `reqX` -> `ackX`.
  - `reqX`/`addrX` -> `rom_address`.
  - All other outputs come straight from registers.
- Reset outputs: `ack0`=`ack1`=0, `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0, `rom_address`=0x00, `busy`=0.

## Configuration
- `J68_DEC_ARB_FIXED_PRIO_EN`:
  - Defined: requester 1 (exception/trace) always wins contention. The `last` pointer is not implemented, and requester 0 can starve while `req1` is held.
  - Undefined (default): round-robin arbitration as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single request: `req0`=1, `addr0`=0x3C, ROM model loaded with the word at 0x3C -> `ack0` in cycle 0, `rom_address`=0x3C, `rvalid0` pulse in cycle 2 with `rdata0`=word[0x3C]; `rvalid1` stays 0.
- Contention after reset: both requests high, `addr0`=0x10, `addr1`=0x20 -> grants go 0,1,0,1…; `rvalid0`/`rvalid1` alternate from cycle 2 with words 0x10/0x20; no gap cycles.
- Fixed-priority build with `J68_DEC_ARB_FIXED_PRIO_EN` defined, same stimulus -> `ack1` every cycle, `ack0` never while `req1`=1.
- Hold/isolation: grant requester 1 at 0xFF, then idle 5 cycles -> `rom_address` stays 0xFF, and `rdata1` holds word[0xFF] after requester 0 reads 0x00.
- Reset mid-operation: grant at cycle N, `reset`=1 in cycle N+1 -> no `rvalid` in N+2; all outputs at reset values; first contention after reset grants requester 0.
- Idle: no requests for 10 cycles -> `busy`=0, `ack`/`rvalid` all 0.

Source files
------------

// File: rtl/j68_decode_arb_if.sv
// Signal bundle between the j68 decode-ROM arbiter, its two requesters
// (instruction decoder on port 0, exception/trace sequencer on port 1)
// and the shared synchronous-read decode ROM.
//
// Handshake: a requester raises reqX with a stable addrX and keeps both
// steady until it observes ackX high in a cycle. ackX is combinational,
// so the lookup is accepted in the cycle ackX is high, and reqX may drop
// on the following cycle. rvalidX is a one-cycle pulse marking rdataX
// as a new word. There is no back-pressure on the read-data side.
//
// The arbiter connects through the slave modport. The master modport is
// the environment side: requesters plus the ROM.
interface j68_decode_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 36
);
  // requester 0: instruction decoder
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              ack0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  // requester 1: exception/trace sequencer
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  // decode ROM side
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  // status
  logic              busy;

  modport slave (
    input  req0, addr0, req1, addr1, rom_q,
    output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, rom_address, busy
  );

  modport master (
    output req0, addr0, req1, addr1, rom_q,
    input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, rom_address, busy
  );
endinterface

// File: rtl/j68_decode_arb.sv
// j68_decode_arb: shares the single synchronous-read j68 decode ROM
// between the instruction decoder (port 0) and the exception/trace
// sequencer (port 1).
//
// - At most one lookup is granted per cycle.
// - A lone requester is granted in the same cycle.
// - A granted read is delivered two cycles later as a registered word,
//   with a one-cycle rvalid pulse to the port that issued it.
//
// Build option: J68_DEC_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin arbitration on contention. A
//                         1-bit 'last' pointer records the most recent
//                         winner, and requester 0 wins the first
//                         contention after reset.
//   defined             : requester 1 always wins contention. There is
//                         no pointer, and requester 0 can starve while
//                         req1 is held.
//
// Clock 'clock', synchronous active-high 'reset'.
module j68_decode_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 36
) (
  input  logic            clock,
  input  logic            reset,
  j68_decode_arb_if.slave bus
);

  // grant decision for the current cycle
  logic              grant0;
  logic              grant1;
  logic              grant_any;

  // last granted address, parked on the ROM when idle
  logic [ADDR_W-1:0] hold_addr;
  logic [ADDR_W-1:0] rom_addr_mux;

  // read pipeline: stage 1 marks a ROM read in flight
  logic              s1_vld;
  logic              s1_tag;   // 0 = requester 0, 1 = requester 1

  // delivery registers
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

`ifdef J68_DEC_ARB_FIXED_PRIO_EN
  // Fixed priority: the exception/trace sequencer always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant1 = bus.req1;
      grant0 = bus.req0 && !bus.req1;
    end
  end
`else
  // Round-robin pointer: the most recently granted requester.
  // Reset value 1 makes requester 0 win the first contention.
  logic last;

  // On contention the requester that is not 'last' wins. A lone
  // requester is granted at once.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = bus.req0;
        grant1 = bus.req1;
      end
    end
  end

  // Update the round-robin pointer on every grant edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_any) begin
      last <= grant1;
    end
  end
`endif

  assign grant_any = grant0 || grant1;

  // ROM address: the granted requester's address, or the parked address
  // when idle so the ROM address lines do not toggle needlessly.
  always_comb begin
    rom_addr_mux = hold_addr;
    if (grant0) begin
      rom_addr_mux = bus.addr0;
    end else if (grant1) begin
      rom_addr_mux = bus.addr1;
    end
  end

  // Capture each granted address so it can be parked on the ROM.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_addr <= '0;
    end else if (grant_any) begin
      hold_addr <= rom_addr_mux;
    end
  end

  // Stage 1: remember that a read was issued this cycle and for whom.
  // Reset drops an in-flight read, so it is never delivered.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_tag <= 1'b0;
    end else begin
      s1_vld <= grant_any;
      s1_tag <= grant1;
    end
  end

  // Stage 2: register the ROM word for the tagged requester and pulse
  // its rvalid. The other requester's data is left untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= s1_vld && !s1_tag;
      rvalid1_q <= s1_vld &&  s1_tag;
      if (s1_vld && !s1_tag) begin
        rdata0_q <= bus.rom_q;
      end
      if (s1_vld && s1_tag) begin
        rdata1_q <= bus.rom_q;
      end
    end
  end

  assign bus.ack0        = grant0;
  assign bus.ack1        = grant1;
  assign bus.rom_address = rom_addr_mux;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.busy        = s1_vld || grant_any;

endmodule

// File: tb/tb_j68_decode_arb.sv
// Bench for j68_decode_arb. A behavioural ROM returns word(a) one cycle
// after address a is presented. A per-cycle vector table is checked,
// followed by a back-to-back single-requester stream that is checked
// against an expected queue.
module tb_j68_decode_arb;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 36;

  logic clock;
  logic reset;

  int total;
  int bad;

  j68_decode_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  j68_decode_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- ROM model ----------------
  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    logic [7:0] s;
    s = a + 8'h3C;
    return {a[3:0] ^ 4'h5, a, ~a, a ^ 8'hA5, s};
  endfunction

  always @(posedge clock) bus.rom_q <= word(bus.rom_address);

  // ---------------- vector table ----------------
  typedef struct {
    logic              rst;
    logic              q0;
    logic [ADDR_W-1:0] a0;
    logic              q1;
    logic [ADDR_W-1:0] a1;
    logic              e_ack0;
    logic              e_ack1;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rv0;
    logic              e_rv1;
    logic [DATA_W-1:0] e_d0;
    logic [DATA_W-1:0] e_d1;
    logic              e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic q0, input logic [7:0] a0,
                     input logic q1, input logic [7:0] a1,
                     input logic e_ack0, input logic e_ack1, input logic [7:0] e_addr,
                     input logic e_rv0, input logic e_rv1,
                     input logic [DATA_W-1:0] e_d0, input logic [DATA_W-1:0] e_d1,
                     input logic e_busy);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.a0 = a0; v.q1 = q1; v.a1 = a1;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_addr = e_addr;
    v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_d0 = e_d0; v.e_d1 = e_d1;
    v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic q0, input logic [7:0] a0,
                       input logic q1, input logic [7:0] a1);
    @(negedge clock);
    reset    = rst;
    bus.req0 = q0;
    bus.addr0 = a0;
    bus.req1 = q1;
    bus.addr1 = a1;
    #1;
  endtask

  // ---------------- scoreboard for the streaming sequence ----------------
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] w00, w3c, wff, w10, w20;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0;

    w00 = word(8'h00); w3c = word(8'h3C); wff = word(8'hFF);
    w10 = word(8'h10); w20 = word(8'h20);

    // idle after reset
    add(0,0,8'h00,0,8'h00, 0,0,8'h00, 0,0, '0,'0, 0);
    // single request from requester 0 at 0x3C
    add(0,1,8'h3C,0,8'h00, 1,0,8'h3C, 0,0, '0,'0, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h3C, 0,0, '0,'0, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h3C, 1,0, w3c,'0, 0);
    add(0,0,8'h00,0,8'h00, 0,0,8'h3C, 0,0, w3c,'0, 0);
    // hold/isolation: requester 1 at 0xFF, then idle 5 cycles
    add(0,0,8'h00,1,8'hFF, 0,1,8'hFF, 0,0, w3c,'0, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'hFF, 0,0, w3c,'0, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'hFF, 0,1, w3c,wff, 0);
    for (int i = 0; i < 3; i++)
      add(0,0,8'h00,0,8'h00, 0,0,8'hFF, 0,0, w3c,wff, 0);
    // requester 0 reads 0x00; requester 1 data must be undisturbed
    add(0,1,8'h00,0,8'h00, 1,0,8'h00, 0,0, w3c,wff, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h00, 0,0, w3c,wff, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h00, 1,0, w00,wff, 0);
    add(0,0,8'h00,0,8'h00, 0,0,8'h00, 0,0, w00,wff, 0);
    // reset one cycle after a grant: the read is dropped
    add(0,0,8'h00,1,8'h55, 0,1,8'h55, 0,0, w00,wff, 1);
    add(1,1,8'h00,1,8'h00, 0,0,8'h55, 0,0, w00,wff, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h00, 0,0, '0,'0, 0);
    // contention straight after reset
`ifdef J68_DEC_ARB_FIXED_PRIO_EN
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,0, '0,'0, 1);
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,0, '0,'0, 1);
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,1, '0,w20, 1);
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,1, '0,w20, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h20, 0,1, '0,w20, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h20, 0,1, '0,w20, 0);
    for (int i = 0; i < 10; i++)
      add(0,0,8'h00,0,8'h00, 0,0,8'h20, 0,0, '0,w20, 0);
`else
    add(0,1,8'h10,1,8'h20, 1,0,8'h10, 0,0, '0,'0, 1);
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,0, '0,'0, 1);
    add(0,1,8'h10,1,8'h20, 1,0,8'h10, 1,0, w10,'0, 1);
    add(0,1,8'h10,1,8'h20, 0,1,8'h20, 0,1, w10,w20, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h20, 1,0, w10,w20, 1);
    add(0,0,8'h00,0,8'h00, 0,0,8'h20, 0,1, w10,w20, 0);
    for (int i = 0; i < 10; i++)
      add(0,0,8'h00,0,8'h00, 0,0,8'h20, 0,0, w10,w20, 0);
`endif

    // reset for three edges, then apply the table
    repeat (3) @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].q0, vecs[i].a0, vecs[i].q1, vecs[i].a1);
      check("ack0",    i, DATA_W'(bus.ack0),        DATA_W'(vecs[i].e_ack0));
      check("ack1",    i, DATA_W'(bus.ack1),        DATA_W'(vecs[i].e_ack1));
      check("rom_addr",i, DATA_W'(bus.rom_address), DATA_W'(vecs[i].e_addr));
      check("rvalid0", i, DATA_W'(bus.rvalid0),     DATA_W'(vecs[i].e_rv0));
      check("rvalid1", i, DATA_W'(bus.rvalid1),     DATA_W'(vecs[i].e_rv1));
      check("rdata0",  i, bus.rdata0,               vecs[i].e_d0);
      check("rdata1",  i, bus.rdata1,               vecs[i].e_d1);
      check("busy",    i, DATA_W'(bus.busy),        DATA_W'(vecs[i].e_busy));
    end

    // back-to-back lookups from requester 0 alone: one grant per cycle,
    // one delivery per cycle two cycles later, in order
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a;
      a = 8'(k * 17 + 3);
      drive(0, (k < 6), a, 0, 8'h00);
      check("strm_ack0", k, DATA_W'(bus.ack0), DATA_W'(k < 6));
      if (k < 6) exp_q.push_back(word(a));
      if (k >= 2) begin
        check("strm_rv0", k, DATA_W'(bus.rvalid0), DATA_W'(1));
        if (exp_q.size() > 0) begin
          check("strm_rdata0", k, bus.rdata0, exp_q.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL strm_queue row=%0d got=empty want=entry", k);
        end
      end else begin
        check("strm_rv0", k, DATA_W'(bus.rvalid0), DATA_W'(0));
      end
      check("strm_rv1", k, DATA_W'(bus.rvalid1), DATA_W'(0));
    end
    drive(0, 0, 8'h00, 0, 8'h00);
    check("strm_tail_rv0", 0, DATA_W'(bus.rvalid0), DATA_W'(0));
    check("strm_tail_busy", 0, DATA_W'(bus.busy), DATA_W'(0));
    check("strm_left", 0, DATA_W'(exp_q.size()), DATA_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
